avalon_sdram_bridge: RTL and testbench

AVALON_SDRAM_BRIDGE -- requirements
Module: avalon_sdram_bridge

---
 rtl/avalon_sdram_bridge_if.sv | 38 +++
 rtl/avalon_sdram_bridge.sv | 124 ++++++++++++
 tb/tb_avalon_sdram_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_sdram_bridge_if.sv
// avalon_sdram_bridge_if: Avalon-MM slave side and SDRAM controller request side of the bridge.
interface avalon_sdram_bridge_if #(
    parameter int ASIZE = 22,
    parameter int DSIZE = 16
);
    logic [ASIZE-1:0]   AV_ADDRESS;
    logic               AV_READ;
    logic               AV_WRITE;
    logic [DSIZE-1:0]   AV_WRITEDATA;
    logic [DSIZE/8-1:0] AV_BYTEENABLE;
    logic [7:0]         AV_BURSTCOUNT;
    logic               AV_WAITREQUEST;
    logic [DSIZE-1:0]   AV_READDATA;
    logic               AV_READDATAVALID;
    logic [ASIZE-1:0]   ADDR;
    logic               WR;
    logic               RD;
    logic [7:0]         LENGTH;
    logic [DSIZE-1:0]   DATAIN;
    logic [DSIZE/8-1:0] DM;
    logic               IN_REQ;
    logic               OUT_VALID;
    logic [DSIZE-1:0]   DATAOUT;
    logic               DONE;
    logic               ERR;
    modport slave (
        input  AV_ADDRESS, AV_READ, AV_WRITE, AV_WRITEDATA, AV_BYTEENABLE, AV_BURSTCOUNT,
               IN_REQ, OUT_VALID, DATAOUT, DONE,
        output AV_WAITREQUEST, AV_READDATA, AV_READDATAVALID,
               ADDR, WR, RD, LENGTH, DATAIN, DM, ERR
    );
    modport master (
        output AV_ADDRESS, AV_READ, AV_WRITE, AV_WRITEDATA, AV_BYTEENABLE, AV_BURSTCOUNT,
               IN_REQ, OUT_VALID, DATAOUT, DONE,
        input  AV_WAITREQUEST, AV_READDATA, AV_READDATAVALID,
               ADDR, WR, RD, LENGTH, DATAIN, DM, ERR
    );
endinterface

// File: rtl/avalon_sdram_bridge.sv
// avalon_sdram_bridge: buffers Avalon write bursts and forwards read bursts to a level-handshake SDRAM controller.
module avalon_sdram_bridge #(
    parameter int ASIZE     = 22,
    parameter int DSIZE     = 16,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 1023
) (
    input logic CLK,
    input logic RESET_N,
    avalon_sdram_bridge_if.slave bus
);
    localparam int MW = DSIZE / 8;
    localparam int PW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WCOLLECT, WISSUE, RISSUE, RDATA, RELEASE} state_t;

    state_t              state;
    logic [DSIZE+MW-1:0] slots [MAX_BURST];
    logic [7:0]          cnt, len, n_eff;
    logic [PW-1:0]       ptr, wslot;
    logic [TW-1:0]       wd;
    logic                timeout;

    assign n_eff = bus.AV_BURSTCOUNT == 8'd0 ? 8'd1 :
                   bus.AV_BURSTCOUNT > 8'(MAX_BURST) ? 8'(MAX_BURST) : bus.AV_BURSTCOUNT;
    // Read pointer saturates on the last slot; beats past the burst are masked off.
    assign ptr     = cnt >= len ? PW'(len - 8'd1) : PW'(cnt);
    assign wslot   = state == IDLE ? '0 : PW'(cnt);
    assign timeout = wd == TW'(TIMEOUT - 1);

    assign bus.DATAIN         = state == WISSUE ? slots[ptr][DSIZE+MW-1:MW] : '0;
    assign bus.DM             = state == WISSUE && cnt < len ? slots[ptr][MW-1:0] : '1;
    assign bus.AV_WAITREQUEST = !RESET_N || !(state == IDLE || state == WCOLLECT);

    always_ff @(posedge CLK)
        if (RESET_N && (state == IDLE || state == WCOLLECT) && bus.AV_WRITE)
            slots[wslot] <= {bus.AV_WRITEDATA, ~bus.AV_BYTEENABLE};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state                <= IDLE;
            bus.WR               <= 1'b0;
            bus.RD               <= 1'b0;
            bus.ADDR             <= '0;
            bus.LENGTH           <= '0;
            bus.AV_READDATA      <= '0;
            bus.AV_READDATAVALID <= 1'b0;
            bus.ERR              <= 1'b0;
            cnt                  <= '0;
            len                  <= '0;
            wd                   <= '0;
        end else begin
            bus.AV_READDATAVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.AV_WRITE) begin
                        bus.ADDR   <= bus.AV_ADDRESS;
                        bus.LENGTH <= n_eff;
                        len        <= n_eff;
                        cnt        <= n_eff == 8'd1 ? 8'd0 : 8'd1;
                        wd         <= '0;
                        bus.WR     <= n_eff == 8'd1;
                        state      <= n_eff == 8'd1 ? WISSUE : WCOLLECT;
                    end else if (bus.AV_READ) begin
                        bus.ADDR   <= bus.AV_ADDRESS;
                        bus.LENGTH <= n_eff;
                        len        <= n_eff;
                        cnt        <= '0;
                        wd         <= '0;
                        bus.RD     <= 1'b1;
                        state      <= RISSUE;
                    end
                end
                WCOLLECT: begin
                    if (bus.AV_WRITE) begin
                        cnt <= cnt == len - 8'd1 ? 8'd0 : cnt + 8'd1;
                        if (cnt == len - 8'd1) begin
                            wd     <= '0;
                            bus.WR <= 1'b1;
                            state  <= WISSUE;
                        end
                    end
                end
                WISSUE: begin
                    if (bus.DONE && cnt >= len) begin
                        bus.WR <= 1'b0;
                        state  <= RELEASE;
                    end else if (timeout) begin
                        bus.ERR <= 1'b1;
                        bus.WR  <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        wd <= wd + TW'(1);
                        if (bus.IN_REQ && cnt < len)
                            cnt <= cnt + 8'd1;
                    end
                end
                RISSUE: begin
                    wd    <= wd + TW'(1);
                    state <= RDATA;
                end
                RDATA: begin
                    if (bus.OUT_VALID && cnt < len) begin
                        bus.AV_READDATA      <= bus.DATAOUT;
                        bus.AV_READDATAVALID <= 1'b1;
                        cnt                  <= cnt + 8'd1;
                    end
                    if (bus.DONE && cnt >= len) begin
                        bus.RD <= 1'b0;
                        state  <= RELEASE;
                    end else if (timeout) begin
                        bus.ERR <= 1'b1;
                        bus.RD  <= 1'b0;
                        state   <= RELEASE;
                    end else
                        wd <= wd + TW'(1);
                end
                RELEASE: if (!bus.DONE) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_sdram_bridge.sv
// tb_avalon_sdram_bridge: randomized Avalon master and SDRAM controller models with a queue scoreboard.
module tb_avalon_sdram_bridge;
    localparam int ASIZE = 22, DSIZE = 16, MAX_BURST = 8, TIMEOUT = 1023;

    typedef struct packed {
        logic             w;
        logic [ASIZE-1:0] a;
        logic [7:0]       n;
    } cmd_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    avalon_sdram_bridge_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();
    avalon_sdram_bridge #(.ASIZE(ASIZE), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT))
        dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

    int tests = 0, fails = 0;
    bit [15:0] ref_mem [int];
    bit [15:0] ctl_mem [int];
    cmd_t        exp_cmd [$];
    logic [17:0] exp_wb  [$];
    logic [15:0] exp_rd  [$];
    bit ctl_extra = 0, ctl_nodone = 0, ctl_stall = 0;
    logic mon_pw = 1'b0, mon_pr = 1'b0, mon_pov = 1'b0;
    cmd_t mon_c;
    logic [17:0] mon_wb;
    logic [15:0] mon_rd;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void bound_fail(string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    function automatic int clip(int bc);
        return bc == 0 ? 1 : (bc > MAX_BURST ? MAX_BURST : bc);
    endfunction

    function automatic bit [15:0] merge(bit [15:0] old, logic [15:0] d, logic [1:0] lanes);
        bit [15:0] m = old;
        if (lanes[0]) m[7:0] = d[7:0];
        if (lanes[1]) m[15:8] = d[15:8];
        return m;
    endfunction

    task automatic ref_write(int a, logic [15:0] d, logic [1:0] be);
        ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 16'h0, d, be);
    endtask

    task automatic accept(output int k);
        k = 0;
        @(negedge CLK);
        while (bus.AV_WAITREQUEST && k < 5000) begin
            k++;
            @(negedge CLK);
        end
        if (k >= 5000) bound_fail("accept");
        @(posedge CLK);
        #1;
    endtask

    task automatic av_write(int addr, int bc, logic [15:0] d0, logic [1:0] be, bit gaps);
        int n = clip(bc);
        int k;
        exp_cmd.push_back('{w: 1'b1, a: ASIZE'(addr), n: 8'(n)});
        for (int i = 0; i < n; i++) begin
            logic [15:0] d = d0 + 16'(i);
            ref_write(addr + i, d, be);
            exp_wb.push_back({d, ~be});
            bus.AV_ADDRESS = ASIZE'(addr);
            bus.AV_BURSTCOUNT = 8'(bc);
            bus.AV_WRITEDATA = d;
            bus.AV_BYTEENABLE = be;
            bus.AV_WRITE = 1'b1;
            if (i > 0) check("wr_low_while_collecting", bus.WR, 0);
            accept(k);
            bus.AV_WRITE = 1'b0;
            if (gaps && i < n - 1) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end
        if (ctl_extra) exp_wb.push_back({d0 + 16'(n - 1), 2'b11});
        check("wr_rises_after_last_beat", bus.WR, 1);
    endtask

    task automatic av_read(int addr, int bc);
        int n = clip(bc);
        int k;
        exp_cmd.push_back('{w: 1'b0, a: ASIZE'(addr), n: 8'(n)});
        for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem.exists(addr + i) ? ref_mem[addr + i] : 16'h0);
        bus.AV_ADDRESS = ASIZE'(addr);
        bus.AV_BURSTCOUNT = 8'(bc);
        bus.AV_READ = 1'b1;
        accept(k);
        bus.AV_READ = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        @(negedge CLK);
        while ((exp_cmd.size() != 0 || exp_wb.size() != 0 || exp_rd.size() != 0 ||
                bus.AV_WAITREQUEST || bus.WR || bus.RD) && k < 3000) begin
            k++;
            @(negedge CLK);
        end
        if (k >= 3000) bound_fail("drain_to_idle");
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drop(bit is_wr);
        int k = 0;
        while ((is_wr ? bus.WR : bus.RD) && k < 3000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (k >= 3000) bound_fail(is_wr ? "wr_drop" : "rd_drop");
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        bus.DONE = 1'b0;
    endtask

    task automatic ctl_write();
        int a = int'(bus.ADDR);
        int n = int'(bus.LENGTH);
        if (!ctl_stall) begin
            for (int i = 0; i < n + int'(ctl_extra); i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                bus.IN_REQ = 1'b1;
                @(negedge CLK);
                if (bus.DM != 2'b11) begin
                    int idx = a + (i < n ? i : n - 1);
                    ctl_mem[idx] = merge(ctl_mem.exists(idx) ? ctl_mem[idx] : 16'h0, bus.DATAIN, ~bus.DM);
                end
                @(posedge CLK);
                #1;
                bus.IN_REQ = 1'b0;
            end
            if (!ctl_nodone) bus.DONE = 1'b1;
        end
        wait_drop(1'b1);
    endtask

    task automatic ctl_read();
        int a = int'(bus.ADDR);
        int n = int'(bus.LENGTH);
        repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
        for (int i = 0; i < n + int'(ctl_extra); i++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge CLK); #1; end
            bus.OUT_VALID = 1'b1;
            bus.DATAOUT = i < n ? (ctl_mem.exists(a + i) ? ctl_mem[a + i] : 16'h0) : 16'($urandom);
            @(posedge CLK);
            #1;
            bus.OUT_VALID = 1'b0;
        end
        bus.DONE = 1'b1;
        wait_drop(1'b0);
    endtask

    initial begin
        bus.IN_REQ = 1'b0;
        bus.OUT_VALID = 1'b0;
        bus.DATAOUT = '0;
        bus.DONE = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET_N && bus.WR) ctl_write();
            else if (RESET_N && bus.RD) ctl_read();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                if ((bus.WR && !mon_pw) || (bus.RD && !mon_pr)) begin
                    check("turnaround_idle_before_request", {mon_pw, mon_pr}, 0);
                    if (exp_cmd.size() == 0) bound_fail("unexpected_request");
                    else begin
                        mon_c = exp_cmd.pop_front();
                        check("request_kind_addr_len", {bus.WR, bus.ADDR, bus.LENGTH}, mon_c);
                    end
                end
                if (bus.WR && bus.IN_REQ) begin
                    if (exp_wb.size() == 0) bound_fail("unexpected_write_beat");
                    else begin
                        mon_wb = exp_wb.pop_front();
                        check("write_beat_datain_dm", {bus.DATAIN, bus.DM}, mon_wb);
                    end
                end
                if (bus.AV_READDATAVALID) begin
                    check("readdatavalid_one_cycle_after_out_valid", mon_pov, 1);
                    if (exp_rd.size() == 0) bound_fail("unexpected_read_beat");
                    else begin
                        mon_rd = exp_rd.pop_front();
                        check("read_beat_data", bus.AV_READDATA, mon_rd);
                    end
                end
            end
            mon_pw = bus.WR;
            mon_pr = bus.RD;
            mon_pov = bus.OUT_VALID;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        bus.AV_ADDRESS = '0;
        bus.AV_READ = 1'b0;
        bus.AV_WRITE = 1'b0;
        bus.AV_WRITEDATA = '0;
        bus.AV_BYTEENABLE = '0;
        bus.AV_BURSTCOUNT = '0;
        for (int i = 0; i < 3; i++) begin
            ref_mem[32'h2000 + i] = 16'h11 * 16'(i + 1);
            ctl_mem[32'h2000 + i] = 16'h11 * 16'(i + 1);
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_wr", bus.WR, 0);
        check("reset_rd", bus.RD, 0);
        check("reset_addr", bus.ADDR, 0);
        check("reset_length", bus.LENGTH, 0);
        check("reset_datain", bus.DATAIN, 0);
        check("reset_dm", bus.DM, 2'b11);
        check("reset_readdata", bus.AV_READDATA, 0);
        check("reset_readdatavalid", bus.AV_READDATAVALID, 0);
        check("reset_err", bus.ERR, 0);
        check("reset_waitrequest", bus.AV_WAITREQUEST, 1);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check("idle_waitrequest", bus.AV_WAITREQUEST, 0);
        @(posedge CLK);
        #1;

        av_write(32'h1000, 4, 16'h00A0, 2'b11, 1'b0);
        drain();
        av_read(32'h2000, 3);
        drain();
        av_write(32'h1100, 0, 16'h1234, 2'b11, 1'b1);
        av_write(32'h1200, 20, 16'h4400, 2'b11, 1'b1);
        av_write(32'h1300, 2, 16'hABCD, 2'b01, 1'b1);
        av_read(32'h1200, 20);
        av_read(32'h1300, 2);
        av_read(32'h1000, 4);
        drain();

        ctl_extra = 1;
        av_write(32'h1400, 3, 16'h7700, 2'b10, 1'b1);
        av_read(32'h1400, 3);
        drain();
        ctl_extra = 0;

        exp_cmd.push_back('{w: 1'b1, a: ASIZE'(32'h1500), n: 8'd1});
        exp_wb.push_back({16'hBEEF, 2'b00});
        ref_write(32'h1500, 16'hBEEF, 2'b11);
        exp_cmd.push_back('{w: 1'b0, a: ASIZE'(32'h1500), n: 8'd1});
        exp_rd.push_back(16'hBEEF);
        bus.AV_ADDRESS = ASIZE'(32'h1500);
        bus.AV_BURSTCOUNT = 8'd1;
        bus.AV_WRITEDATA = 16'hBEEF;
        bus.AV_BYTEENABLE = 2'b11;
        bus.AV_WRITE = 1'b1;
        bus.AV_READ = 1'b1;
        accept(k);
        bus.AV_WRITE = 1'b0;
        accept(k);
        bus.AV_READ = 1'b0;
        check("read_stalled_behind_write", k > 0, 1);
        drain();

        for (int t = 0; t < 30; t++) begin
            int a = 32'h3000 + int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                av_write(a, int'($urandom_range(0, 10)), 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
            else
                av_read(a, int'($urandom_range(0, 10)));
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        end
        drain();
        check("err_clear_before_timeout", bus.ERR, 0);

        ctl_nodone = 1;
        av_write(32'h4000, 2, 16'h5550, 2'b11, 1'b0);
        k = 0;
        while (!bus.ERR && k < 2 * TIMEOUT) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (k >= 2 * TIMEOUT) bound_fail("timeout_err");
        check("timeout_latency_in_range", k >= TIMEOUT - 2 && k <= TIMEOUT + 2, 1);
        check("timeout_err_set", bus.ERR, 1);
        check("timeout_wr_dropped", bus.WR, 0);
        drain();
        ctl_nodone = 0;
        av_read(32'h4000, 2);
        drain();
        check("err_sticky", bus.ERR, 1);

        ctl_stall = 1;
        av_write(32'h5000, 1, 16'h6600, 2'b11, 1'b0);
        RESET_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midburst_reset_wr", bus.WR, 0);
        check("midburst_reset_err", bus.ERR, 0);
        check("midburst_reset_length", bus.LENGTH, 0);
        check("midburst_reset_waitrequest", bus.AV_WAITREQUEST, 1);
        exp_cmd.delete();
        exp_wb.delete();
        exp_rd.delete();
        ref_mem.delete(32'h5000);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check("after_reset_idle_waitrequest", bus.AV_WAITREQUEST, 0);
        ctl_stall = 0;
        @(posedge CLK);
        #1;
        av_read(32'h1000, 4);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
